free_list: RTL and testbench

FREE_LIST -- requirements
Module: free_list

---
 rtl/free_list.sv | 46 ++++
 tb/tb_free_list.sv | 127 ++++++++++++
 2 files changed

// File: rtl/free_list.sv
// free_list: circular free list of physical register tags; dequeue/phys_reg at head, enqueue at tail, flush refills, free_count/is_free_list_empty from pointers
module free_list #(
  parameter int PHYS_REG_BITS = 6,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dequeue,
  output logic [PHYS_REG_BITS-1:0] phys_reg,
  output logic                     is_free_list_empty,
  input  logic                     enqueue,
  input  logic [PHYS_REG_BITS-1:0] enqueue_preg,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   free_count
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  logic [PHYS_REG_BITS-1:0] mem_q [DEPTH];
  logic [PHYS_REG_BITS-1:0] mem_d [DEPTH];
  logic [IW:0] head_q, head_d, tail_q, tail_d;
  logic full, enq_ok, deq_ok;
  assign full = head_q[IW-1:0] == tail_q[IW-1:0] && head_q[IW] != tail_q[IW];
  assign is_free_list_empty = head_q == tail_q;
  assign free_count = tail_q - head_q;
  assign phys_reg = mem_q[head_q[IW-1:0]];
  assign enq_ok = enqueue && enqueue_preg != '0 && !full;
  assign deq_ok = dequeue && !is_free_list_empty && !flush;
  always_comb begin
    tail_d = tail_q + PW'(enq_ok);
    head_d = flush ? {~tail_d[IW], tail_d[IW-1:0]} : head_q + PW'(deq_ok);
    mem_d = mem_q;
    if (enq_ok) mem_d[tail_q[IW-1:0]] = enqueue_preg;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= {1'b1, {IW{1'b0}}};
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= PHYS_REG_BITS'(32 + i);
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      mem_q <= mem_d;
    end
  end
  a_enq_full: assert property (@(posedge clk) disable iff (rst) !(enqueue && enqueue_preg != '0 && full));
endmodule

// File: tb/tb_free_list.sv
// tb_free_list: scoreboard bench for free_list; directed vectors then modelled random traffic
module tb_free_list;
  logic clk = 0, rst, dequeue, enqueue, flush;
  logic [5:0] phys_reg, enqueue_preg, free_count;
  logic is_free_list_empty;
  typedef struct {
    string nm;
    bit cp;
    logic [5:0] p;
    logic [5:0] c;
    bit em;
  } exp_t;
  exp_t sb[$];
  exp_t x;
  int n_cmp = 0, n_bad = 0;
  logic [5:0] win[$];
  bit inw[64];
  int cnt;

  free_list #(.PHYS_REG_BITS(6), .DEPTH(32)) dut (
    .clk(clk), .rst(rst), .dequeue(dequeue), .phys_reg(phys_reg),
    .is_free_list_empty(is_free_list_empty), .enqueue(enqueue),
    .enqueue_preg(enqueue_preg), .flush(flush), .free_count(free_count)
  );

  always #5 clk = ~clk;

  task automatic step(input bit r, d, e, input logic [5:0] pg, input bit f,
                      input string nm, input bit cp, input logic [5:0] p, c, input bit em);
    rst = r; dequeue = d; enqueue = e; enqueue_preg = pg; flush = f;
    @(posedge clk);
    #1;
    sb.push_back('{nm, cp, p, c, em});
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      x = sb.pop_front();
      n_cmp++;
      if (free_count !== x.c) begin
        n_bad++;
        $display("FAIL %s free_count got %0d want %0d", x.nm, free_count, x.c);
      end
      n_cmp++;
      if (is_free_list_empty !== x.em) begin
        n_bad++;
        $display("FAIL %s empty got %0b want %0b", x.nm, is_free_list_empty, x.em);
      end
      if (x.cp) begin
        n_cmp++;
        if (phys_reg !== x.p) begin
          n_bad++;
          $display("FAIL %s phys_reg got %0d want %0d", x.nm, phys_reg, x.p);
        end
      end
      if (is_free_list_empty === 1'b0) begin
        n_cmp++;
        if (phys_reg === 6'd0) begin
          n_bad++;
          $display("FAIL %s tag0_on_head got %0d want nonzero", x.nm, phys_reg);
        end
      end
    end
  end

  initial begin
    rst = 1; dequeue = 0; enqueue = 0; enqueue_preg = 0; flush = 0;
    step(1, 0, 0, 0, 0, "reset", 1, 32, 32, 0);
    for (int i = 1; i <= 32; i++)
      step(0, 1, 0, 0, 0, "deq_seq", i < 32, 6'(32 + i), 6'(32 - i), i == 32);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, "deq_empty", 0, 0, 0, 1);
    step(0, 1, 1, 45, 0, "enq_deq_empty", 1, 45, 1, 0);
    step(0, 1, 0, 0, 0, "deq_last", 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, "reset2", 1, 32, 32, 0);
    for (int i = 1; i <= 5; i++) step(0, 1, 0, 0, 0, "deq5", 1, 6'(32 + i), 6'(32 - i), 0);
    step(0, 1, 1, 0, 1, "flush", 1, 32, 32, 0);
    for (int i = 1; i <= 22; i++) step(0, 1, 0, 0, 0, "deq22", 1, 6'(32 + i), 6'(32 - i), 0);
    step(0, 1, 1, 50, 0, "enq_deq", 1, 55, 10, 0);
    for (int k = 1; k <= 9; k++) step(0, 1, 0, 0, 0, "drain", 1, k < 9 ? 6'(55 + k) : 6'd50, 6'(10 - k), 0);
    step(0, 0, 1, 0, 0, "enq_zero", 1, 50, 1, 0);
    step(1, 1, 1, 7, 1, "reset_mid", 1, 32, 32, 0);
    for (int t = 32; t < 64; t++) begin
      win.push_back(6'(t));
      inw[t] = 1;
    end
    cnt = 32;
    for (int n = 0; n < 10000; n++) begin
      bit d, e, f, dq;
      logic [5:0] pg, ep;
      int pool[$];
      d = 1'($urandom_range(0, 1));
      f = $urandom_range(0, 31) == 0;
      e = 0;
      pg = 0;
      if (cnt < 32 && $urandom_range(0, 1) == 1) begin
        e = 1;
        if ($urandom_range(0, 9) != 0) begin
          for (int t = 1; t < 64; t++) if (!inw[t]) pool.push_back(t);
          pg = 6'(pool[$urandom_range(0, pool.size() - 1)]);
        end
      end
      dq = d && cnt > 0 && !f;
      if (e && pg != 0) begin
        inw[win[0]] = 0;
        void'(win.pop_front());
        win.push_back(pg);
        inw[pg] = 1;
        cnt++;
      end
      if (dq) cnt--;
      if (f) cnt = 32;
      ep = 0;
      if (cnt > 0) ep = win[32 - cnt];
      step(0, d, e, pg, f, "rand", cnt > 0, ep, 6'(cnt), cnt == 0);
    end
    dequeue = 0; enqueue = 0; flush = 0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending got %0d want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
